id_ex_pipeline_reg: RTL and testbench

- Decode-to-execute pipeline register for the 5-stage pipelined RV32I core.
- Sits directly downstream of the main decoder / ALU decoder and register file.
- Captures the decode-stage control bundle, operands, immediate and register indices every cycle for the execute stage.
- Supports stall (hold), flush (bubble insertion for load-use and taken branch/jump) and a per-entry valid bit.

---
 rtl/core_pkg.sv | 57 +++++
 rtl/id_ex_pipeline_reg_if.sv | 55 +++++
 rtl/id_ex_pipeline_reg_sat_counter.sv | 31 +++
 rtl/id_ex_pipeline_reg.sv | 110 +++++++++++
 tb/tb_id_ex_pipeline_reg.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core constants, encodings and stage bundles
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
    } ctrl_bundle_t;

    typedef struct packed {
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   imm_ext;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
    } data_bundle_t;

    // Invalid entries must never cause architectural side effects downstream.
    function automatic ctrl_bundle_t gate_ctrl(input ctrl_bundle_t c, input logic valid);
        ctrl_bundle_t g;
        g = c;
        if (!valid) begin
            g.reg_write = 1'b0;
            g.mem_write = 1'b0;
            g.jump      = 1'b0;
            g.branch    = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/id_ex_pipeline_reg_if.sv
// rtl/id_ex_pipeline_reg_if.sv - decode-side inputs and execute-side outputs of the ID/EX register
interface id_ex_pipeline_reg_if;
    import core_pkg::*;

    logic              StallE;
    logic              FlushE;
    logic              ValidD;
    logic              RegWriteD;
    logic              MemWriteD;
    logic              JumpD;
    logic              BranchD;
    logic              ALUSrcD;
    logic [1:0]        ResultSrcD;
    logic [2:0]        ALUControlD;
    logic [XLEN-1:0]   RD1D;
    logic [XLEN-1:0]   RD2D;
    logic [XLEN-1:0]   PCD;
    logic [XLEN-1:0]   PCPlus4D;
    logic [XLEN-1:0]   ImmExtD;
    logic [REG_AW-1:0] Rs1D;
    logic [REG_AW-1:0] Rs2D;
    logic [REG_AW-1:0] RdD;

    logic              ValidE;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              JumpE;
    logic              BranchE;
    logic              ALUSrcE;
    logic [1:0]        ResultSrcE;
    logic [2:0]        ALUControlE;
    logic [XLEN-1:0]   RD1E;
    logic [XLEN-1:0]   RD2E;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [XLEN-1:0]   ImmExtE;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;

    modport master (
        output StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
               ResultSrcD, ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        input  ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
    );

    modport slave (
        input  StallE, FlushE, ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
               ResultSrcD, ALUControlD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD,
        output ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
               ALUControlE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE
    );

endinterface

// File: rtl/id_ex_pipeline_reg_sat_counter.sv
// rtl/id_ex_pipeline_reg_sat_counter.sv - saturating event counter with async active-low reset
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - ID/EX pipeline register with stall, flush and valid gating
// Optional stall/bubble performance counters under ID_EX_PERF_CNT_EN.
module id_ex_pipeline_reg
    import core_pkg::*;
`ifdef ID_EX_PERF_CNT_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic                  clk,
    input  logic                  rst,
    id_ex_pipeline_reg_if.slave   bus
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]      BubbleCnt,
    output logic [CNT_W-1:0]      StallCnt
`endif
);

    logic         valid_q, valid_d;
    ctrl_bundle_t ctrl_q,  ctrl_d;
    data_bundle_t data_q,  data_d;
    ctrl_bundle_t ctrl_in;
    data_bundle_t data_in;

    always_comb begin
        ctrl_in.reg_write   = bus.RegWriteD;
        ctrl_in.result_src  = bus.ResultSrcD;
        ctrl_in.mem_write   = bus.MemWriteD;
        ctrl_in.jump        = bus.JumpD;
        ctrl_in.branch      = bus.BranchD;
        ctrl_in.alu_control = bus.ALUControlD;
        ctrl_in.alu_src     = bus.ALUSrcD;
        data_in.rd1         = bus.RD1D;
        data_in.rd2         = bus.RD2D;
        data_in.pc          = bus.PCD;
        data_in.pc_plus4    = bus.PCPlus4D;
        data_in.imm_ext     = bus.ImmExtD;
        data_in.rs1         = bus.Rs1D;
        data_in.rs2         = bus.Rs2D;
        data_in.rd          = bus.RdD;
    end

    // Flush outranks stall so a load-use bubble can't be swallowed by a hold.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (bus.FlushE) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            data_d  = '0;
        end else if (!bus.StallE) begin
            valid_d = bus.ValidD;
            ctrl_d  = gate_ctrl(ctrl_in, bus.ValidD);
            data_d  = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign bus.ValidE      = valid_q;
    assign bus.RegWriteE   = ctrl_q.reg_write;
    assign bus.ResultSrcE  = ctrl_q.result_src;
    assign bus.MemWriteE   = ctrl_q.mem_write;
    assign bus.JumpE       = ctrl_q.jump;
    assign bus.BranchE     = ctrl_q.branch;
    assign bus.ALUControlE = ctrl_q.alu_control;
    assign bus.ALUSrcE     = ctrl_q.alu_src;
    assign bus.RD1E        = data_q.rd1;
    assign bus.RD2E        = data_q.rd2;
    assign bus.PCE         = data_q.pc;
    assign bus.PCPlus4E    = data_q.pc_plus4;
    assign bus.ImmExtE     = data_q.imm_ext;
    assign bus.Rs1E        = data_q.rs1;
    assign bus.Rs2E        = data_q.rs2;
    assign bus.RdE         = data_q.rd;

`ifdef ID_EX_PERF_CNT_EN
    logic stall_only;

    assign stall_only = bus.StallE & ~bus.FlushE;

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.FlushE),
        .count (BubbleCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_only),
        .count (StallCnt)
    );
`endif

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb/tb_id_ex_pipeline_reg.sv - directed self-checking bench for id_ex_pipeline_reg
module tb_id_ex_pipeline_reg;
    import core_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic       sat_inc;
    logic [2:0] sat_count;

    id_ex_pipeline_reg_if bus ();

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt;
    logic [31:0] stall_cnt;

    id_ex_pipeline_reg #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .BubbleCnt (bubble_cnt),
        .StallCnt  (stall_cnt)
    );
`else
    id_ex_pipeline_reg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    sat_counter #(.CNT_W(3)) u_sat (
        .clk   (clk),
        .rst   (rst),
        .inc   (sat_inc),
        .count (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic rw, input logic mw, input logic j,
                       input logic b, input logic as, input logic [1:0] rs,
                       input logic [2:0] ac, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        bus.ValidD      = v;
        bus.RegWriteD   = rw;
        bus.MemWriteD   = mw;
        bus.JumpD       = j;
        bus.BranchD     = b;
        bus.ALUSrcD     = as;
        bus.ResultSrcD  = rs;
        bus.ALUControlD = ac;
        bus.RD1D        = r1;
        bus.RD2D        = r2;
        bus.PCD         = pc;
        bus.PCPlus4D    = pc + 32'd4;
        bus.ImmExtD     = imm;
        bus.Rs1D        = s1;
        bus.Rs2D        = s2;
        bus.RdD         = d;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        sat_inc    = 1'b0;
        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        drv(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, RES_PC4, ALU_SLT, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 5'd31, 5'd31, 5'd31);

        #12;
        chk("reset_valid", {31'd0, bus.ValidE}, 32'd0);
        chk("reset_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
        chk("reset_rd1", bus.RD1E, 32'd0);
        chk("reset_rd", {27'd0, bus.RdE}, 32'd0);
        chk("reset_pcplus4", bus.PCPlus4E, 32'd0);

        rst = 1'b1;
        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, RES_MEM, ALU_ADD, 32'h0000_1000,
            32'd0, 32'h0000_0040, 32'd4, 5'd2, 5'd0, 5'd5);
        tick();
        chk("lw_valid", {31'd0, bus.ValidE}, 32'd1);
        chk("lw_regwrite", {31'd0, bus.RegWriteE}, 32'd1);
        chk("lw_ressrc", {30'd0, bus.ResultSrcE}, 32'd1);
        chk("lw_rd", {27'd0, bus.RdE}, 32'd5);

        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus.ValidE}, 32'd0);
        chk("midrst_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
        chk("midrst_ressrc", {30'd0, bus.ResultSrcE}, 32'd0);
        chk("midrst_rd", {27'd0, bus.RdE}, 32'd0);
        chk("midrst_rd1", bus.RD1E, 32'd0);
        chk("midrst_alusrc", {31'd0, bus.ALUSrcE}, 32'd0);
        tick();
        chk("rst_held_valid", {31'd0, bus.ValidE}, 32'd0);
        chk("rst_held_imm", bus.ImmExtE, 32'd0);
        #2;
        rst = 1'b1;

        drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, RES_ALU, ALU_ADD, 32'h0000_0010,
            32'h0000_0003, 32'h0000_0200, 32'd0, 5'd1, 5'd2, 5'd7);
        tick();
        chk("rtype_valid", {31'd0, bus.ValidE}, 32'd1);
        chk("rtype_rd1", bus.RD1E, 32'h10);
        chk("rtype_rd2", bus.RD2E, 32'h3);
        chk("rtype_rd", {27'd0, bus.RdE}, 32'd7);
        chk("rtype_regwrite", {31'd0, bus.RegWriteE}, 32'd1);
        chk("rtype_pc", bus.PCE, 32'h200);
        chk("rtype_pcplus4", bus.PCPlus4E, 32'h204);
        chk("rtype_rs1", {27'd0, bus.Rs1E}, 32'd1);
        chk("rtype_rs2", {27'd0, bus.Rs2E}, 32'd2);

        bus.StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(i[0], 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, RES_PC4, ALU_OR, 32'h1000 + i,
                32'h2000 + i, 32'h3000, 32'h55, 5'd8, 5'd9, 5'(10 + i));
            tick();
            chk("stall_rd1", bus.RD1E, 32'h10);
            chk("stall_rd", {27'd0, bus.RdE}, 32'd7);
            chk("stall_valid", {31'd0, bus.ValidE}, 32'd1);
            chk("stall_regwrite", {31'd0, bus.RegWriteE}, 32'd1);
            chk("stall_memwrite", {31'd0, bus.MemWriteE}, 32'd0);
        end
        bus.StallE = 1'b0;
        drv(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, RES_ALU, ALU_SUB, 32'h0000_00AA,
            32'h0000_00BB, 32'h0000_0300, 32'h40, 5'd3, 5'd4, 5'd9);
        tick();
        chk("unstall_rd1", bus.RD1E, 32'hAA);
        chk("unstall_branch", {31'd0, bus.BranchE}, 32'd1);
        chk("unstall_rd", {27'd0, bus.RdE}, 32'd9);
        chk("unstall_imm", bus.ImmExtE, 32'h40);
        chk("unstall_aluctl", {29'd0, bus.ALUControlE}, {29'd0, ALU_SUB});
        chk("unstall_regwrite", {31'd0, bus.RegWriteE}, 32'd0);

        bus.FlushE = 1'b1;
        drv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, RES_ALU, ALU_ADD, 32'h50, 32'h60,
            32'h400, 32'h8, 5'd5, 5'd6, 5'd12);
        tick();
        chk("flush_memwrite", {31'd0, bus.MemWriteE}, 32'd0);
        chk("flush_valid", {31'd0, bus.ValidE}, 32'd0);
        chk("flush_rd", {27'd0, bus.RdE}, 32'd0);
        chk("flush_rd2", bus.RD2E, 32'd0);
        chk("flush_pc", bus.PCE, 32'd0);
        chk("flush_alusrc", {31'd0, bus.ALUSrcE}, 32'd0);

        bus.FlushE = 1'b0;
        tick();
        chk("sw_memwrite", {31'd0, bus.MemWriteE}, 32'd1);
        chk("sw_valid", {31'd0, bus.ValidE}, 32'd1);
        chk("sw_rd", {27'd0, bus.RdE}, 32'd12);

        bus.StallE = 1'b1;
        bus.FlushE = 1'b1;
        tick();
        chk("flushstall_memwrite", {31'd0, bus.MemWriteE}, 32'd0);
        chk("flushstall_valid", {31'd0, bus.ValidE}, 32'd0);
        chk("flushstall_rd", {27'd0, bus.RdE}, 32'd0);
        chk("flushstall_rd1", bus.RD1E, 32'd0);

        bus.StallE = 1'b0;
        bus.FlushE = 1'b0;
        drv(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, RES_PC4, ALU_ADD, 32'h11, 32'h22,
            32'h100, 32'h8, 5'd1, 5'd2, 5'd3);
        tick();
        chk("inval_jump", {31'd0, bus.JumpE}, 32'd0);
        chk("inval_branch", {31'd0, bus.BranchE}, 32'd0);
        chk("inval_regwrite", {31'd0, bus.RegWriteE}, 32'd0);
        chk("inval_memwrite", {31'd0, bus.MemWriteE}, 32'd0);
        chk("inval_valid", {31'd0, bus.ValidE}, 32'd0);
        chk("inval_pc", bus.PCE, 32'h100);
        chk("inval_rd", {27'd0, bus.RdE}, 32'd3);
        chk("inval_ressrc", {30'd0, bus.ResultSrcE}, 32'd2);
        chk("inval_rd1", bus.RD1E, 32'h11);

        drv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, RES_PC4, ALU_ADD, 32'd0, 32'd0,
            32'h500, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        chk("x0_regwrite", {31'd0, bus.RegWriteE}, 32'd1);
        chk("x0_jump", {31'd0, bus.JumpE}, 32'd1);
        chk("x0_rd", {27'd0, bus.RdE}, 32'd0);
        chk("x0_valid", {31'd0, bus.ValidE}, 32'd1);

`ifdef ID_EX_PERF_CNT_EN
        rst = 1'b0;
        #1;
        chk("cnt_reset_bubble", bubble_cnt, 32'd0);
        chk("cnt_reset_stall", stall_cnt, 32'd0);
        rst = 1'b1;
        bus.FlushE = 1'b1;
        repeat (3) tick();
        bus.StallE = 1'b1;
        tick();
        bus.FlushE = 1'b0;
        repeat (2) tick();
        bus.StallE = 1'b0;
        tick();
        chk("cnt_bubble", bubble_cnt, 32'd4);
        chk("cnt_stall", stall_cnt, 32'd2);
`endif

        rst = 1'b0;
        #1;
        chk("sat_reset", {29'd0, sat_count}, 32'd0);
        rst = 1'b1;
        sat_inc = 1'b1;
        repeat (3) tick();
        chk("sat_count3", {29'd0, sat_count}, 32'd3);
        repeat (4) tick();
        chk("sat_count7", {29'd0, sat_count}, 32'd7);
        repeat (2) tick();
        chk("sat_hold_max", {29'd0, sat_count}, 32'd7);
        sat_inc = 1'b0;
        tick();
        chk("sat_idle", {29'd0, sat_count}, 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
